// File: rtl/conv_pkg.sv
// Shared constants and width helpers for the convolution MAC datapath.
package conv_pkg;

    // Post-processing selectors for conv_post_proc.
    localparam int MODE_CLAMP = 0;   // negative results become 0
    localparam int MODE_ABS   = 1;   // absolute value (edge magnitude)

    // Default sample and coefficient widths of the convolution datapath.
    localparam int DEF_PIX_W = 8;
    localparam int DEF_KER_W = 8;

    // Accumulator width that holds a full window of signed products without
    // overflow: pixel (+1 sign bit) times coefficient, plus log2(taps) growth.
    function automatic int acc_width(input int pix_w, input int ker_w, input int taps);
        return pix_w + ker_w + $clog2(taps) + 1;
    endfunction

endpackage

// File: rtl/conv_post_proc.sv
// Combinational post-processing of a window sum: normalising arithmetic
// shift, rectification (clamp or absolute value) and saturation to OUT_W.
module conv_post_proc
    import conv_pkg::*;
#(
    parameter int ACC_W = 21,
    parameter int SHIFT = 0,
    parameter int OUT_W = 8,
    parameter int MODE  = MODE_CLAMP
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic        [OUT_W-1:0] data,
    output logic                    sat
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic signed [ACC_W-1:0] v;
    logic signed [ACC_W-1:0] mag;

    // Floor division by 2^SHIFT; the sign is preserved by the arithmetic shift.
    assign v = sum >>> SHIFT;

    // Rectify, then saturate anything above the largest output code.
    always_comb begin
        mag  = v;
        data = v[OUT_W-1:0];
        sat  = 1'b0;
        if (MODE == MODE_ABS && v[ACC_W-1]) begin
            mag = -v;
        end
        if (MODE == MODE_CLAMP && v[ACC_W-1]) begin
            data = '0;
        end else if (mag > MAX_V) begin
            data = '1;
            sat  = 1'b1;
        end else begin
            data = mag[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/conv_mac_array.sv
// Windowed multiply-accumulate for the convolution datapath: accepts one
// (pixel, coefficient) beat at a time, sums TAPS signed products and hands
// one post-processed pixel to the write-back stage.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_valid/pixel/coeff must hold until accepted; out_valid holds
// with out_data/out_sat stable until the consumer raises out_ready.
module conv_mac_array
    import conv_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int KER_W = DEF_KER_W,
    parameter int TAPS  = 9,
    parameter int SHIFT = 0,
    parameter int OUT_W = 8,
    parameter int MODE  = MODE_CLAMP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         pixel,
    input  logic [KER_W-1:0]         coeff,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_sat,
    output logic [$clog2(TAPS)-1:0]  tap_cnt
);

    localparam int ACC_W = acc_width(PIX_W, KER_W, TAPS);
    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    logic signed [ACC_W-1:0] pix_ext;
    logic signed [ACC_W-1:0] coeff_ext;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] s1_prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic                    s1_valid;
    logic                    s1_last;
    logic                    accept;
    logic                    load;
    logic [OUT_W-1:0]        pp_data;
    logic                    pp_sat;

    // Pixel is unsigned, so it gets a zero sign bit; the coefficient is sign-extended.
    assign pix_ext   = {{(ACC_W-PIX_W){1'b0}}, pixel};
    assign coeff_ext = {{(ACC_W-KER_W){coeff[KER_W-1]}}, coeff};
    assign prod      = pix_ext * coeff_ext;

    // Stall while a last tap sits in stage 1 so the output register is only
    // loaded when it is empty or being drained on the same edge.
    assign in_ready = !clear && !(s1_valid && s1_last) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign sum      = acc + s1_prod;
    assign load     = s1_valid && s1_last && !clear;

    conv_post_proc #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W),
        .MODE  (MODE)
    ) u_post_proc (
        .sum  (sum),
        .data (pp_data),
        .sat  (pp_sat)
    );

    // Stage 1: register the product and track the tap position in the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt  <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
        end else if (clear) begin
            tap_cnt  <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod <= prod;
                s1_last <= (tap_cnt == LAST_TAP);
                tap_cnt <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + 1'b1;
            end
        end
    end

    // Stage 2: accumulate, restarting from zero after each window's last tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (s1_valid) begin
            acc <= s1_last ? '0 : sum;
        end
    end

    // Output register: loads a finished window, empties on a completed handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= pp_data;
            out_sat   <= pp_sat;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_mac_array.sv
// Directed bench for conv_mac_array: three instances share one input stream
// (clamp, absolute value, and SHIFT=4 normalised) so every window checks all
// three post-processing variants against hand-computed results.
module tb_conv_mac_array;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] pixel;
    logic [7:0] coeff;

    logic       in_ready_c, in_ready_a, in_ready_n;
    logic       out_valid_c, out_valid_a, out_valid_n;
    logic [7:0] out_data_c, out_data_a, out_data_n;
    logic       out_sat_c, out_sat_a, out_sat_n;
    logic [3:0] tap_cnt_c, tap_cnt_a, tap_cnt_n;

    conv_mac_array #(.TAPS(9), .SHIFT(0), .OUT_W(8), .MODE(0)) u_clamp (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_c),
        .pixel(pixel), .coeff(coeff), .out_valid(out_valid_c), .out_ready(out_ready),
        .out_data(out_data_c), .out_sat(out_sat_c), .tap_cnt(tap_cnt_c)
    );

    conv_mac_array #(.TAPS(9), .SHIFT(0), .OUT_W(8), .MODE(1)) u_abs (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
        .pixel(pixel), .coeff(coeff), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_sat(out_sat_a), .tap_cnt(tap_cnt_a)
    );

    conv_mac_array #(.TAPS(9), .SHIFT(4), .OUT_W(8), .MODE(0)) u_norm (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_n),
        .pixel(pixel), .coeff(coeff), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_data(out_data_n), .out_sat(out_sat_n), .tap_cnt(tap_cnt_n)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int acc_cyc = 0;
    int lat;
    bit bp_done;

    logic [26:0] exp_q[$];
    logic [26:0] sb_exp;

    logic [7:0] k_ones  [9];
    logic [7:0] k_sobel [9];
    logic [7:0] k_gauss [9];
    logic [7:0] p_ramp  [9];
    logic [7:0] p_flat  [9];
    logic [7:0] p_edge  [9];
    logic [7:0] p_mirr  [9];
    logic [7:0] p_100   [9];
    logic [7:0] p_one   [9];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected result record: {sat,data} for clamp, abs and normalised instances.
    function automatic logic [26:0] pk(input logic [7:0] d0, input logic s0,
                                       input logic [7:0] d1, input logic s1,
                                       input logic [7:0] d2, input logic s2);
        return {s0, d0, s1, d1, s2, d2};
    endfunction

    // Scoreboard: every completed output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid_c && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", 32'(1), 32'(0));
            end else begin
                sb_exp = exp_q.pop_front();
                check("result",
                      32'({out_sat_c, out_data_c, out_sat_a, out_data_a, out_sat_n, out_data_n}),
                      32'(sb_exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] p, input logic [7:0] c);
        bit done = 1'b0;
        in_valid = 1'b1;
        pixel    = p;
        coeff    = c;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready_c) begin
                acc_cyc = cyc;
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) check("beat_accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic send_window(input logic [7:0] px [9], input logic [7:0] cf [9],
                               input logic [26:0] exp, input bit push);
        if (push) exp_q.push_back(exp);
        for (int i = 0; i < 9; i++) send_beat(px[i], cf[i]);
    endtask

    task automatic wait_valid(output int l);
        l = -1;
        for (int k = 0; k < 30 && l < 0; k++) begin
            @(negedge clk);
            if (out_valid_c) l = cyc - acc_cyc;
        end
        if (l < 0) check("valid_timeout", 32'(0), 32'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pixel = '0; coeff = '0; bp_done = 1'b0;

        k_ones  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        k_sobel = '{8'hFF, 8'd0, 8'd1, 8'hFE, 8'd0, 8'd2, 8'hFF, 8'd0, 8'd1};
        k_gauss = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd2, 8'd1};
        p_ramp  = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18};
        p_flat  = '{8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
        p_edge  = '{8'd0, 8'd128, 8'd255, 8'd0, 8'd128, 8'd255, 8'd0, 8'd128, 8'd255};
        p_mirr  = '{8'd255, 8'd128, 8'd0, 8'd255, 8'd128, 8'd0, 8'd255, 8'd128, 8'd0};
        p_100   = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
        p_one   = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid_c), 32'(0));
        check("rst_out_data",  32'(out_data_c),  32'(0));
        check("rst_out_sat",   32'(out_sat_c),   32'(0));
        check("rst_tap_cnt",   32'(tap_cnt_c),   32'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Ones kernel over a ramp: 10+..+18 = 126; 126>>>4 = 7.
        send_window(p_ramp, k_ones, pk(8'd126, 1'b0, 8'd126, 1'b0, 8'd7, 1'b0), 1'b1);
        check("ones_tap_cnt_wrap", 32'(tap_cnt_c), 32'(0));
        wait_valid(lat);
        check("ones_latency", 32'(lat), 32'(2));
        idle(2);

        // Sobel Gx windows back to back (no gap between windows).
        send_window(p_flat, k_sobel, pk(8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0), 1'b1);
        send_window(p_edge, k_sobel, pk(8'd255, 1'b1, 8'd255, 1'b1, 8'd63, 1'b0), 1'b1);
        send_window(p_mirr, k_sobel, pk(8'd0, 1'b0, 8'd255, 1'b1, 8'd0, 1'b0), 1'b1);
        // Gaussian on flat 100: sum 1600, normalised to 100.
        send_window(p_100, k_gauss, pk(8'd255, 1'b1, 8'd255, 1'b1, 8'd100, 1'b0), 1'b1);
        idle(4);
        check("stream_drained", 32'(exp_q.size()), 32'(0));

        // Back-pressure: first result held while the second window waits.
        out_ready = 1'b0;
        send_window(p_ramp, k_ones, pk(8'd126, 1'b0, 8'd126, 1'b0, 8'd7, 1'b0), 1'b1);
        @(negedge clk);
        check("bp_s1_last_stall", 32'(in_ready_c), 32'(0));
        check("bp_not_yet_valid", 32'(out_valid_c), 32'(0));
        fork
            begin
                send_window(p_flat, k_ones, pk(8'd255, 1'b1, 8'd255, 1'b1, 8'd112, 1'b0), 1'b1);
                bp_done = 1'b1;
            end
        join_none
        repeat (6) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid_c), 32'(1));
            check("bp_hold_data",  32'(out_data_c),  32'(126));
            check("bp_in_ready",   32'(in_ready_c),  32'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && !bp_done; k++) @(posedge clk);
        #1;
        check("bp_second_window_done", 32'(bp_done), 32'(1));
        idle(4);
        check("bp_drained", 32'(exp_q.size()), 32'(0));

        // clear after 4 taps, then a clean window of ones.
        for (int i = 0; i < 4; i++) send_beat(8'd50, 8'd1);
        check("pre_clear_tap_cnt", 32'(tap_cnt_c), 32'(4));
        clear = 1'b1; in_valid = 1'b1; pixel = 8'd77; coeff = 8'd1;
        @(negedge clk);
        check("clear_in_ready", 32'(in_ready_c), 32'(0));
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        check("clear_tap_cnt", 32'(tap_cnt_c), 32'(0));
        send_window(p_one, k_ones, pk(8'd9, 1'b0, 8'd9, 1'b0, 8'd0, 1'b0), 1'b1);
        check("clear_win_tap_cnt", 32'(tap_cnt_c), 32'(0));
        idle(4);
        check("clear_drained", 32'(exp_q.size()), 32'(0));

        // clear while a result is pending: result survives.
        out_ready = 1'b0;
        send_window(p_one, k_ones, pk(8'd9, 1'b0, 8'd9, 1'b0, 8'd0, 1'b0), 1'b1);
        wait_valid(lat);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clear_keeps_valid", 32'(out_valid_c), 32'(1));
        check("clear_keeps_data",  32'(out_data_c),  32'(9));
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(3);
        check("clear_pending_drained", 32'(exp_q.size()), 32'(0));

        // clear coinciding with the last tap in stage 1: no result.
        send_window(p_ramp, k_ones, '0, 1'b0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("clear_last_no_out", 32'(out_valid_c), 32'(0));
        end
        check("clear_last_tap_cnt", 32'(tap_cnt_c), 32'(0));
        @(posedge clk); #1;

        // Async reset mid-window, then a clean window with no residue.
        for (int i = 0; i < 5; i++) send_beat(8'd200, 8'd1);
        check("pre_rst_tap_cnt", 32'(tap_cnt_c), 32'(5));
        rst = 1'b1;
        #1;
        check("rst_mid_tap_cnt",   32'(tap_cnt_c),   32'(0));
        check("rst_mid_out_valid", 32'(out_valid_c), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        send_window(p_ramp, k_ones, pk(8'd126, 1'b0, 8'd126, 1'b0, 8'd7, 1'b0), 1'b1);
        idle(4);
        check("rst_mid_drained", 32'(exp_q.size()), 32'(0));

        // Async reset while a saturated result is pending.
        out_ready = 1'b0;
        send_window(p_flat, k_ones, '0, 1'b0);
        wait_valid(lat);
        check("pre_rst_sat", 32'(out_sat_c), 32'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_valid_out_valid", 32'(out_valid_c), 32'(0));
        check("rst_valid_out_data",  32'(out_data_c),  32'(0));
        check("rst_valid_out_sat",   32'(out_sat_c),   32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send_window(p_one, k_ones, pk(8'd9, 1'b0, 8'd9, 1'b0, 8'd0, 1'b0), 1'b1);
        idle(4);

        check("final_queue_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/conv_mac_array.md
Name: conv_mac_array

Overview:
- Parametrised successor to the single-tap pixel accumulator used by the convolution datapath.
- Takes one (pixel, kernel coefficient) pair per accepted beat from the RAM reader and kernel address generator.
- Accumulates a full window of TAPS products with signed arithmetic, then normalises, clamps or rectifies the sum.
- Presents one output pixel through a valid/ready handshake to the write-back stage.

Parameters:
- PIX_W, 8, pixel width; unsigned, zero-extended.
- KER_W, 8, coefficient width; two's-complement signed.
- TAPS, 9, products per window; must be >= 2.
- SHIFT, 0, arithmetic right shift applied to the final sum (kernel normalisation).
- OUT_W, 8, output pixel width.
- MODE, 0, post-processing: 0 = clamp negatives to 0; 1 = absolute value (edge magnitude).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous window abort.
- in_valid  in  1  pixel/coeff beat valid.
- in_ready  out  1  block can accept a beat.
- pixel  in  PIX_W  image sample.
- coeff  in  KER_W  signed kernel coefficient.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  processed result.
- out_sat  out  1  result was clamped to 2^OUT_W-1.
- tap_cnt  out  clog2(TAPS)  taps accumulated in the current window (debug).

Behaviour:
- Local ACC_W = PIX_W+KER_W+clog2(TAPS)+1. Product is the signed product of {0,pixel} and coeff, sign-extended to ACC_W. No accumulator overflow is possible.
- Reset (rst=1, async): tap_cnt=0, acc=0, stage-1 valid=0, out_valid=0, out_data=0, out_sat=0. Reset mid-window discards all partial state.
- Accept: a beat is accepted when in_valid && in_ready.
- in_ready = !clear && !(s1_valid && s1_last) && (!out_valid || out_ready). This is combinational; no X-propagation tricks.
- Pipeline stage 1 (edge after accept):
  - register the product, s1_valid=1;
  - s1_last=1 if tap_cnt==TAPS-1;
  - tap_cnt increments, wrapping to 0 after the last tap.
- Stage 2 (next edge, when s1_valid):
  - if !s1_last: acc += product;
  - if s1_last: sum = acc + product, acc=0, output register loads.
- Latency: out_valid rises 2 cycles after the last tap is accepted.
- Output processing:
  - v = sum >>> SHIFT (floor).
  - MODE 0: v<0 gives 0 with out_sat=0.
  - MODE 1: v = |v|.
  - If v > 2^OUT_W-1, then out_data = 2^OUT_W-1 and out_sat=1; otherwise out_data = v[OUT_W-1:0] and out_sat=0.
- Output handshake:
  - out_valid holds, with out_data/out_sat stable, until out_valid && out_ready.
  - It then drops the next cycle unless a new result loads on the same edge; back-to-back results are allowed.
- Back-pressure: while the output register is full and not being drained, in_ready=0. The s1_last term guarantees the output register is never overwritten.
- clear=1:
  - next edge tap_cnt=0, acc=0, s1_valid=0;
  - no beat is accepted that cycle;
  - the output register is untouched, so a pending result still completes its handshake.
- clear in the same cycle as a stage-1 last beat: the last beat is discarded, no output is produced.
- tap_cnt wrap: exactly TAPS products per output. There is no gap cycle required between windows.

Decomposition:
- Shared package conv_pkg: MODE_CLAMP=0, MODE_ABS=1 constants; the ACC_W width function; the default PIX_W/KER_W.
- One natural sub-module: conv_post_proc (combinational shift/rectify/saturate, parametrised by ACC_W, SHIFT, OUT_W, MODE). Reused by future multi-channel variants.

Test Plan:
- Ones kernel, TAPS=9, SHIFT=0, MODE=0: coeff=1 with pixels 10..18 streamed continuously -> out_data=126, out_sat=0, out_valid 2 cycles after the 9th accept.
- Sobel Gx [-1,0,1,-2,0,2,-1,0,1]:
  - pixels flat 200 -> out_data=0;
  - left column 0, right column 255 -> sum 1020 -> out_data=255, out_sat=1;
  - mirrored image, MODE=0 -> out_data=0, out_sat=0;
  - mirrored image, MODE=1 -> out_data=255, out_sat=1.
- Gaussian [1,2,1,2,4,2,1,2,1], SHIFT=4, pixels all 100 -> sum 1600 -> out_data=100.
- Back-pressure: out_ready=0 for 6 cycles while a second window streams -> in_ready=0 once stage-1 holds that window's last tap; first result stable throughout; both results delivered in order after out_ready=1.
- clear after 4 taps, then a full ones-kernel window of pixel=1 -> exactly one result, out_data=9, tap_cnt returns to 0. clear while out_valid=1 -> result retained.
- Assert rst for one cycle mid-window (tap_cnt=5) and while out_valid=1 -> all outputs 0 immediately; the next full window produces the correct sum with no residue.
